serial_comparator_ctrl: RTL



---
 rtl/serial_comparator_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/serial_comparator_ctrl.sv
// rtl/serial_comparator_ctrl.sv - bit-serial MSB-first unsigned magnitude comparator
//
// Compares two unsigned WIDTH-bit operands one bit pair per clock, starting
// at the MSB and stopping at the first differing bit.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  compare request, sampled only while idle
//   a, b   operands, captured on the accepting edge
//   busy   registered: operation in progress (RUN or DONE)
//   done   one-cycle pulse, g/e/l valid while high
//   g/e/l  a>b / a==b / a<b, held until the next result
module serial_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             g,
    output logic             e,
    output logic             l
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [IW-1:0]    idx;

    logic bit_gt;
    logic bit_lt;
    logic bit_eq;

    // Current bit pair under evaluation.
    assign bit_gt = ra[idx] & ~rb[idx];
    assign bit_lt = ~ra[idx] & rb[idx];
    assign bit_eq = ~(ra[idx] ^ rb[idx]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                // idx==0 with equal bits means the operands are equal; never
                // decrement past zero.
                if (!bit_eq || (idx == '0)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra   <= '0;
            rb   <= '0;
            idx  <= IDX_MSB;
            g    <= 1'b0;
            e    <= 1'b0;
            l    <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            // busy/done follow the next state so they are flops, not a
            // combinational function of start.
            busy <= (next_state == RUN) || (next_state == DONE);
            done <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ra  <= a;
                        rb  <= b;
                        idx <= IDX_MSB;
                    end
                end
                RUN: begin
                    if (!bit_eq) begin
                        g <= bit_gt;
                        e <= 1'b0;
                        l <= bit_lt;
                    end else if (idx == '0) begin
                        g <= 1'b0;
                        e <= 1'b1;
                        l <= 1'b0;
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
